cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) between the two execution-result producers: the ALU path (RS_EX) and the load/store path (LS_EX). Each producer writes into a small per-source FIFO. A round-robin arbiter pops at most one entry per cycle and broadcasts it on a registered bus. The ROB, RS, LSB and dispatch forwarding logic all consume that bus. On ROB rollback the block flushes all buffered results so no squashed value is ever broadcast.

---
 rtl/cdb_arbiter_if.sv | 32 +++
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer-side and broadcast-side signals of the common data bus.
//   alu_*  : ALU result offer (valid/rob_id/data) and FIFO ready back to producer
//   ls_*   : load/store result offer and FIFO ready back to producer
//   cdb_*  : registered broadcast (valid, rob_id, data, src: 0=ALU 1=LS)
// slave  = the arbiter, master = producers/consumers (or a testbench).
interface cdb_arbiter_if #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32
);
  logic                    alu_valid;
  logic [ROB_ID_WIDTH-1:0] alu_rob_id;
  logic [DATA_WIDTH-1:0]   alu_data;
  logic                    alu_ready;
  logic                    ls_valid;
  logic [ROB_ID_WIDTH-1:0] ls_rob_id;
  logic [DATA_WIDTH-1:0]   ls_data;
  logic                    ls_ready;
  logic                    cdb_valid;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id;
  logic [DATA_WIDTH-1:0]   cdb_data;
  logic                    cdb_src;

  modport slave (
    input  alu_valid, alu_rob_id, alu_data, ls_valid, ls_rob_id, ls_data,
    output alu_ready, ls_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_src
  );

  modport master (
    output alu_valid, alu_rob_id, alu_data, ls_valid, ls_rob_id, ls_data,
    input  alu_ready, ls_ready, cdb_valid, cdb_rob_id, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two per-source result FIFOs (ALU, LS) feeding one registered
// common data bus through a round-robin arbiter.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   rdy      : global ready; low freezes every register
//   rollback : flush both FIFOs, kill the broadcast, drop this cycle's offers
//   bus      : cdb_arbiter_if.slave (producer offers/readies, cdb_* broadcast)

// Per-source circular FIFO. push/pop arrive already qualified by the parent.
module cdb_src_fifo #(
  parameter int EW    = 36,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [EW-1:0] push_entry,
  input  logic          pop,
  output logic          ready,
  output logic          nempty,
  output logic [EW-1:0] head_entry
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][EW-1:0] mem;
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count;

  // Ready looks only at the current count: a full FIFO refuses a push even
  // in a cycle where it is being popped.
  assign ready      = !rst && (count < CW'(DEPTH));
  assign nempty     = (count != '0);
  assign head_entry = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;   // DEPTH is a power of two: natural wrap
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end
endmodule

module cdb_arbiter #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rollback,
  cdb_arbiter_if.slave  bus
);
  localparam int   EW      = ROB_ID_WIDTH + DATA_WIDTH;
  localparam int   NSRC    = 2;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LS  = 1'b1;

  logic [NSRC-1:0]         offer, ready, nempty, push, pop;
  logic [NSRC-1:0][EW-1:0] push_entry, head_entry;
  logic                    last_grant, pick, both, any;

  logic                    cdb_valid_q, cdb_src_q;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q;
  logic [DATA_WIDTH-1:0]   cdb_data_q;

  assign offer         = {bus.ls_valid, bus.alu_valid};
  assign push_entry[0] = {bus.alu_rob_id, bus.alu_data};
  assign push_entry[1] = {bus.ls_rob_id, bus.ls_data};
  assign bus.alu_ready = ready[0];
  assign bus.ls_ready  = ready[1];

  // Offers during a stall or a rollback cycle are simply not taken.
  assign push = offer & ready & {NSRC{rdy && !rollback}};

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      cdb_src_fifo #(.EW(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (rdy && rollback),
        .push      (push[g]),
        .push_entry(push_entry[g]),
        .pop       (pop[g]),
        .ready     (ready[g]),
        .nempty    (nempty[g]),
        .head_entry(head_entry[g])
      );
    end
  endgenerate

  // Round robin: on a tie the source that did not win the last tie goes.
  always_comb begin
    both = &nempty;
    any  = |nempty;
    pick = both ? ~last_grant : nempty[1];
    pop  = '0;
    if (rdy && !rollback && any) pop[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= SRC_ALU;
      last_grant   <= SRC_LS;
    end else if (rdy) begin
      if (rollback) begin
        cdb_valid_q <= 1'b0;
        last_grant  <= SRC_LS;
      end else if (any) begin
        cdb_valid_q                <= 1'b1;
        {cdb_rob_id_q, cdb_data_q} <= head_entry[pick];
        cdb_src_q                  <= pick;
        if (both) last_grant <= pick;
      end else begin
        cdb_valid_q <= 1'b0;   // tag/data/src keep their last value
      end
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_data   = cdb_data_q;
  assign bus.cdb_src    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: stimulus pushes the hand-derived
// broadcast order into exp_q; a negedge monitor pops and compares each new
// broadcast (one per rdy-high edge with cdb_valid set).
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst, rdy, rollback;
  logic last_rdy = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [36:0] exp_q[$];   // {src, rob_id, data}

  cdb_arbiter_if #(.ROB_ID_WIDTH(4), .DATA_WIDTH(32)) bus ();

  cdb_arbiter #(.ROB_ID_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) last_rdy <= rdy;

  // Monitor: a broadcast is new only if the edge that produced it had rdy high.
  always @(negedge clk) begin
    if (!rst && bus.cdb_valid && last_rdy) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_bcast: got src=%0d id=%0h data=%0h, required none",
                 bus.cdb_src, bus.cdb_rob_id, bus.cdb_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.cdb_src, bus.cdb_rob_id, bus.cdb_data} !== e) begin
          miscompares++;
          $display("FAIL bcast: got src=%0d id=%0h data=%0h, required src=%0d id=%0h data=%0h",
                   bus.cdb_src, bus.cdb_rob_id, bus.cdb_data, e[36], e[35:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_b(input logic src, input logic [3:0] id, input logic [31:0] d);
    exp_q.push_back({src, id, d});
  endtask

  task automatic drive_alu(input logic v, input logic [3:0] id, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_rob_id = id; bus.alu_data = d;
  endtask

  task automatic drive_ls(input logic v, input logic [3:0] id, input logic [31:0] d);
    bus.ls_valid = v; bus.ls_rob_id = id; bus.ls_data = d;
  endtask

  task automatic clear_in();
    drive_alu(1'b0, 4'h0, 32'h0);
    drive_ls(1'b0, 4'h0, 32'h0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Drain, then pulse rollback so every scenario starts empty with last_grant=LS.
  task automatic reset_arb(input string name);
    drain(name);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
  endtask

  initial begin
    int ai, li;
    logic a_off, l_off;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    clear_in();
    tick(); tick();
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst_ls_ready",  64'(bus.ls_ready),  64'd0);
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_cdb_bus",   64'({bus.cdb_src, bus.cdb_rob_id, bus.cdb_data}), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("post_rst_ls_ready",  64'(bus.ls_ready),  64'd1);

    // Tie after reset: ALU wins first.
    tick();
    drive_alu(1'b1, 4'd1, 32'hA1);
    drive_ls(1'b1, 4'd2, 32'hB2);
    expect_b(1'b0, 4'd1, 32'hA1);
    expect_b(1'b1, 4'd2, 32'hB2);
    tick(); clear_in();
    tick(); tick();
    reset_arb("tie_drain");

    // Single ALU result, minimum latency, one-cycle valid.
    drive_alu(1'b1, 4'd3, 32'h11);
    expect_b(1'b0, 4'd3, 32'h11);
    tick(); clear_in();
    chk("single_no_bypass", 64'(bus.cdb_valid), 64'd0);
    tick();
    chk("single_valid", 64'(bus.cdb_valid), 64'd1);
    tick();
    chk("single_valid_drop", 64'(bus.cdb_valid), 64'd0);
    reset_arb("single_drain");

    // Sustained contention: strict ALU/LS alternation, ids 0..7 each.
    for (int k = 0; k < 8; k++) begin
      expect_b(1'b0, 4'(k), 32'hA00 + k);
      expect_b(1'b1, 4'(k), 32'hB00 + k);
    end
    ai = 0; li = 0;
    for (int c = 0; c < 60 && (ai < 8 || li < 8); c++) begin
      a_off = (ai < 8) && bus.alu_ready;
      l_off = (li < 8) && bus.ls_ready;
      drive_alu(a_off, 4'(ai), 32'hA00 + ai);
      drive_ls(l_off, 4'(li), 32'hB00 + li);
      tick();
      if (a_off) ai++;
      if (l_off) li++;
    end
    clear_in();
    chk("contention_all_pushed", 64'(ai + li), 64'd16);
    reset_arb("contention_drain");

    // Full LS FIFO refuses id 6; ready returns after a pop.
    drive_alu(1'b1, 4'd8, 32'hC8);
    drive_ls(1'b1, 4'd4, 32'hD4);
    expect_b(1'b0, 4'd8, 32'hC8);
    expect_b(1'b1, 4'd4, 32'hD4);
    expect_b(1'b0, 4'd9, 32'hC9);
    expect_b(1'b1, 4'd5, 32'hD5);
    tick();
    drive_alu(1'b1, 4'd9, 32'hC9);
    drive_ls(1'b1, 4'd5, 32'hD5);
    tick();
    chk("ls_full_ready", 64'(bus.ls_ready), 64'd0);
    chk("alu_not_full_ready", 64'(bus.alu_ready), 64'd1);
    drive_alu(1'b0, 4'd0, 32'h0);
    drive_ls(1'b1, 4'd6, 32'hD6);
    tick();
    chk("ls_ready_after_pop", 64'(bus.ls_ready), 64'd1);
    clear_in();
    reset_arb("full_drain");

    // Rollback with buffered entries and live offers: nothing stale escapes.
    drive_alu(1'b1, 4'd1, 32'hE1);
    drive_ls(1'b1, 4'd1, 32'hF1);
    expect_b(1'b0, 4'd1, 32'hE1);
    tick();
    drive_alu(1'b1, 4'd2, 32'hE2);
    drive_ls(1'b1, 4'd2, 32'hF2);
    tick();
    rollback = 1'b1;
    drive_alu(1'b1, 4'hF, 32'hEF);
    drive_ls(1'b1, 4'hE, 32'hFE);
    tick();
    rollback = 1'b0;
    clear_in();
    chk("rb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rb_alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("rb_ls_ready", 64'(bus.ls_ready), 64'd1);
    drive_alu(1'b1, 4'hC, 32'h3C);
    expect_b(1'b0, 4'hC, 32'h3C);
    tick(); clear_in();
    chk("rb_no_stale", 64'(bus.cdb_valid), 64'd0);
    tick();
    chk("rb_first_new", 64'(bus.cdb_valid), 64'd1);
    tick(); tick();
    reset_arb("rb_drain");

    // rdy low for 3 cycles while id 7 is on the bus.
    drive_alu(1'b1, 4'd7, 32'h77);
    drive_ls(1'b1, 4'd9, 32'h99);
    expect_b(1'b0, 4'd7, 32'h77);
    expect_b(1'b1, 4'd9, 32'h99);
    tick(); clear_in();
    tick();
    rdy = 1'b0;
    drive_alu(1'b1, 4'hD, 32'hDD);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 64'(bus.cdb_valid), 64'd1);
      chk("stall_bus", 64'({bus.cdb_src, bus.cdb_rob_id, bus.cdb_data}), 64'({1'b0, 4'd7, 32'h77}));
    end
    clear_in();
    chk("stall_ls_ready", 64'(bus.ls_ready), 64'd1);
    rdy = 1'b1;
    tick();
    chk("resume_src", 64'(bus.cdb_src), 64'd1);
    tick(); tick();
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
